pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program counter and fetch-sequencing stage that sits directly downstream of the branch-offset lookup table.
- Consumes the 8-bit relative branch offset produced by the lookup table when a taken branch is signalled, and produces the instruction-memory address each cycle.
- Also owns the program start/done handshake with the testbench, and keeps a retired-instruction counter for performance checks.

Parameters:
- D, 12, program counter width in bits; instruction memory depth is 2^D.
- T, 8, branch offset width in bits; the offset is signed two's complement.
- START_ADDR, 0, PC value loaded on each accepted start.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level/pulse request to begin program execution; sampled only in IDLE or DONE.
- stall  input  1  hold PC this cycle; no retire.
- branch_en  input  1  taken-branch indication from decode/ALU for the current instruction.
- target  input  T  signed relative offset from the branch-offset lookup table.
- halt_req  input  1  current instruction is the program terminator.
- prog_ctr  output  D  current instruction address.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- icount  output  16  count of retired instructions since the last accepted start; saturates at 16'hFFFF.

Behaviour:
- Reset (asynchronous, active-high), while asserted:
  - state=IDLE, prog_ctr=0, icount=0, running=0, done=0.
  - Reset asserted mid-RUN aborts immediately; there is no completion and no done pulse.
- States: IDLE, RUN, DONE. running and done are registered decodes of the state.
- IDLE:
  - start=1 -> next edge: prog_ctr=START_ADDR, icount=0, state=RUN.
  - Otherwise hold everything.
- RUN, with per-edge priority halt_req > stall > branch_en > sequential:
  - halt_req=1 -> state=DONE; prog_ctr holds; icount increments (the halt instruction retires). halt_req is honoured even if stall=1.
  - stall=1 (no halt) -> prog_ctr and icount hold; branch_en is ignored.
  - branch_en=1 -> prog_ctr = (prog_ctr + sign_extend(target, D)) mod 2^D; icount+1.
  - Otherwise -> prog_ctr = (prog_ctr + 1) mod 2^D; icount+1.
  - start is ignored.
- DONE:
  - prog_ctr and icount hold; done=1.
  - start=1 -> reload exactly as from IDLE, with done dropping on the same edge that running rises.
- Arithmetic:
  - target is sign-extended from bit T-1 to D bits, so 8'h86 is -122, not +134.
  - The sum is truncated to D bits; wrap-around in either direction is legal and is not flagged.
- Latency:
  - The next-PC decision uses the current cycle's inputs; the new prog_ctr is visible one cycle after the edge.
  - There are no delay slots; branch and sequential updates take the same single cycle.
- icount saturates and never wraps.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset at power-up, start=1 for 1 cycle, then 5 cycles with no branch -> prog_ctr walks 0,1,2,3,4,5; icount=5; running=1, done=0.
- Forward branch at PC=20 with target=8'd15, branch_en=1 -> next prog_ctr=35; backward branch at PC=20 with target=8'hF9 (-7) -> next prog_ctr=13.
- Sign-extension and wrap: PC=130 with target=8'h86 -> 8; PC=5 with target=8'hF9 -> 4094 (D=12); PC=4095 sequential -> 0.
- Stall interaction: stall=1 together with branch_en=1 at PC=10 for 2 cycles -> prog_ctr stays 10 and icount is unchanged; stall then drops with the branch still asserted -> offset is applied once.
- Halt handling: halt_req=1 together with stall=1 at PC=40 -> DONE, prog_ctr=40, done=1, icount incremented; start=1 in DONE -> prog_ctr=0, icount=0, running=1 on the same edge that done falls.
- Asynchronous reset mid-RUN at PC=57 -> prog_ctr=0, state IDLE and done=0 asserted before the next clock edge; start asserted in RUN has no effect.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE control with relative branches,
// stall/halt handling and a saturating retired-instruction counter.
module pc_fetch_ctrl #(
    parameter int             D          = 12,
    parameter int             T          = 8,
    parameter logic [D-1:0]   START_ADDR = '0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           stall,
    input  logic           branch_en,
    input  logic [T-1:0]   target,
    input  logic           halt_req,
    output logic [D-1:0]   prog_ctr,
    output logic           running,
    output logic           done,
    output logic [15:0]    icount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [D-1:0]   offset_ext;
    logic [D-1:0]   pc_seq;
    logic [15:0]    icount_inc;

    // Offset is two's complement, so replicate its sign bit up to the PC width.
    assign offset_ext = {{(D-T){target[T-1]}}, target};
    assign pc_seq     = prog_ctr + {{(D-1){1'b0}}, 1'b1};
    assign icount_inc = (icount == 16'hFFFF) ? icount : icount + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            prog_ctr <= '0;
            icount   <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        prog_ctr <= START_ADDR;
                        icount   <= '0;
                        running  <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    // Halt wins over stall: the terminator retires even when stalled.
                    if (halt_req) begin
                        state   <= DONE;
                        icount  <= icount_inc;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (!stall) begin
                        icount   <= icount_inc;
                        prog_ctr <= branch_en ? (prog_ctr + offset_ext) : pc_seq;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: the driver pushes model predictions per cycle,
// an independent monitor pops and compares them after every clock edge.
module tb_pc_fetch_ctrl;

    localparam int D = 12;
    localparam int T = 8;
    localparam int PC_MOD = 1 << D;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           stall;
    logic           branch_en;
    logic [T-1:0]   target;
    logic           halt_req;
    logic [D-1:0]   prog_ctr;
    logic           running;
    logic           done;
    logic [15:0]    icount;

    pc_fetch_ctrl #(.D(D), .T(T), .START_ADDR(12'd0)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .branch_en (branch_en),
        .target    (target),
        .halt_req  (halt_req),
        .prog_ctr  (prog_ctr),
        .running   (running),
        .done      (done),
        .icount    (icount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        bit run;
        bit dn;
        int ic;
        int id;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   verbose = 1'b1;
    int   txn = 0;

    // Behavioural model: mode 0=idle, 1=run, 2=done
    int m_mode = 0;
    int m_pc   = 0;
    int m_ic   = 0;

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_ic   = 0;
    endtask

    task automatic retire();
        if (m_ic < 65535) m_ic = m_ic + 1;
    endtask

    task automatic step(input bit s, input bit st, input bit br, input int tgt, input bit h);
        exp_t e;
        int off;
        @(negedge clk);
        start     = s;
        stall     = st;
        branch_en = br;
        target    = tgt[T-1:0];
        halt_req  = h;
        if (m_mode != 1) begin
            if (s) begin
                m_mode = 1;
                m_pc   = 0;
                m_ic   = 0;
            end
        end else if (h) begin
            m_mode = 2;
            retire();
        end else if (!st) begin
            off  = (tgt >= 128) ? tgt - 256 : tgt;
            m_pc = br ? (((m_pc + off) % PC_MOD) + PC_MOD) % PC_MOD : (m_pc + 1) % PC_MOD;
            retire();
        end
        txn++;
        e.pc  = m_pc;
        e.run = (m_mode == 1);
        e.dn  = (m_mode == 2);
        e.ic  = m_ic;
        e.id  = txn;
        exp_q.push_back(e);
        if (verbose)
            $display("[TB] txn %0d start=%0b stall=%0b br=%0b tgt=%02h halt=%0b -> exp pc=%0d run=%0b done=%0b ic=%0d",
                     txn, s, st, br, tgt[7:0], h, e.pc, e.run, e.dn, e.ic);
    endtask

    task automatic check_now(input string name, input int pc, input bit run, input bit dn, input int ic);
        tests++;
        if (prog_ctr !== pc[D-1:0] || running !== run || done !== dn || icount !== ic[15:0]) begin
            fails++;
            $display("FAIL %s: got pc=%0d run=%0b done=%0b ic=%0d, expected pc=%0d run=%0b done=%0b ic=%0d",
                     name, prog_ctr, running, done, icount, pc, run, dn, ic);
        end
    endtask

    // Monitor: the DUT presents a new registered state after every edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (prog_ctr !== e.pc[D-1:0] || running !== e.run || done !== e.dn || icount !== e.ic[15:0]) begin
                fails++;
                $display("FAIL txn%0d: got pc=%0d run=%0b done=%0b ic=%0d, expected pc=%0d run=%0b done=%0b ic=%0d",
                         e.id, prog_ctr, running, done, icount, e.pc, e.run, e.dn, e.ic);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 0; stall = 0; branch_en = 0; target = '0; halt_req = 0;
        #12;
        check_now("power_up_reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        step(0, 0, 0, 0, 0);                       // idle hold
        step(1, 0, 0, 0, 0);                       // start
        repeat (5) step(0, 0, 0, 0, 0);            // walk to 5
        step(0, 0, 1, 15, 0);                      // 5 -> 20
        step(0, 0, 1, 15, 0);                      // 20 -> 35
        step(0, 0, 1, 8'hF1, 0);                   // 35 -> 20
        step(0, 0, 1, 8'hF9, 0);                   // 20 -> 13
        step(0, 0, 1, 117, 0);                     // 13 -> 130
        step(0, 0, 1, 8'h86, 0);                   // 130 -> 8
        step(0, 0, 1, 8'hFD, 0);                   // 8 -> 5
        step(0, 0, 1, 8'hF9, 0);                   // 5 -> 4094
        step(0, 0, 0, 0, 0);                       // 4095
        step(0, 0, 0, 0, 0);                       // wrap to 0
        step(0, 0, 1, 10, 0);                      // 0 -> 10
        step(0, 1, 1, 20, 0);                      // stalled branch
        step(0, 1, 1, 20, 0);
        step(0, 0, 1, 20, 0);                      // 10 -> 30 once
        step(1, 0, 1, 10, 0);                      // start ignored in RUN, 30 -> 40
        step(0, 1, 0, 0, 1);                       // halt with stall
        step(0, 0, 1, 5, 0);                       // DONE holds
        step(1, 0, 0, 0, 0);                       // restart
        step(0, 0, 1, 57, 0);                      // 0 -> 57
        step(1, 0, 0, 0, 0);                       // start in RUN ignored -> 58
        step(0, 0, 1, 8'hFF, 0);                   // 58 -> 57

        // Asynchronous reset between edges must act before the next clock edge.
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_now("async_reset_midrun", 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        #1;
        check_now("reset_held", 0, 0, 0, 0);
        reset = 1'b0;

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 255)), $urandom_range(0, 24) == 0);
        end

        // icount saturation: long run with transaction printing suppressed
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        verbose = 1'b0;
        for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 0);
        verbose = 1'b1;
        $display("[TB] saturation run of 65540 sequential transactions issued");
        step(0, 0, 0, 0, 1);                       // halt at saturation
        step(1, 0, 0, 0, 0);                       // restart clears icount
        step(0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
